// File: rtl/cassette_pkg.sv
// Shared definitions for the cassette save/load blocks: FSM states,
// TAP file-type codes, framing constants and small byte helpers.
package cassette_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_RDREQ   = 3'd2,
    ST_RDWAIT  = 3'd3,
    ST_BODY    = 3'd4,
    ST_CHECK   = 3'd5,
    ST_TRAILER = 3'd6,
    ST_FIN     = 3'd7
  } cassette_state_t;

  localparam logic [7:0]  FT_BASIC   = 8'h42;
  localparam logic [7:0]  FT_MACHINE = 8'h4D;
  localparam logic [7:0]  FT_DATA    = 8'h44;
  localparam logic [7:0]  FT_ASCII   = 8'h41;
  localparam logic [7:0]  QUOTE_BYTE = 8'h22;
  localparam logic [15:0] BASIC_BASE = 16'h694D;

  // True for the four file types the tape format knows about.
  function automatic logic is_supported(input logic [7:0] ftype);
    case (ftype)
      FT_BASIC, FT_MACHINE, FT_DATA, FT_ASCII: is_supported = 1'b1;
      default:                                 is_supported = 1'b0;
    endcase
  endfunction

  // Running check digit: plain modulo-256 byte sum.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    csum_add = sum + data;
  endfunction

  // Header byte at position idx. Positions 5..8 only exist for machine-code files.
  function automatic logic [7:0] hdr_byte(
    input logic [3:0]  idx,
    input logic [7:0]  ftype,
    input logic [15:0] len,
    input logic [15:0] load,
    input logic [15:0] exec
  );
    case (idx)
      4'd0:    hdr_byte = QUOTE_BYTE;
      4'd1:    hdr_byte = QUOTE_BYTE;
      4'd2:    hdr_byte = ftype;
      4'd3:    hdr_byte = len[7:0];
      4'd4:    hdr_byte = len[15:8];
      4'd5:    hdr_byte = load[7:0];
      4'd6:    hdr_byte = load[15:8];
      4'd7:    hdr_byte = exec[7:0];
      4'd8:    hdr_byte = exec[15:8];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/cassette_save.sv
// Cassette save engine: frames one TAP file (header, memory body, optional
// check digit and trailer) onto a valid/ready byte stream.
module cassette_save #(
  parameter logic [7:0]  TRAILER_BYTE = 8'h00,
  parameter logic [15:0] BASIC_BASE   = cassette_pkg::BASIC_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  file_type,
  input  logic [15:0] load_point,
  input  logic [15:0] exec_point,
  input  logic [15:0] prog_length,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [24:0] tx_count,
  output logic        busy,
  output logic        done,
  output logic        error
);
  import cassette_pkg::*;

  cassette_state_t state_r, state_s;
  logic [3:0]  hdr_idx_r, hdr_idx_s;
  logic [15:0] remain_r, remain_s;
  logic [7:0]  checksum_r, checksum_s;
  logic [7:0]  ftype_r, ftype_s;
  logic [15:0] len_r, len_s;
  logic [15:0] load_r, load_s;
  logic [15:0] exec_r, exec_s;
  logic [15:0] mem_addr_r, mem_addr_s;
  logic        mem_rd_r, mem_rd_s;
  logic [7:0]  tx_data_r, tx_data_s;
  logic        tx_valid_r, tx_valid_s;
  logic [24:0] tx_count_r, tx_count_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        error_r, error_s;

  logic        xfer_s;
  logic [3:0]  hdr_last_s;
  logic        is_basic_s;

  assign xfer_s     = tx_valid_r & tx_ready;
  assign is_basic_s = (ftype_r == FT_BASIC);
  assign hdr_last_s = (ftype_r == FT_MACHINE) ? 4'd8 : 4'd4;

  assign mem_addr = mem_addr_r;
  assign mem_rd   = mem_rd_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign tx_count = tx_count_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s    = state_r;
    hdr_idx_s  = hdr_idx_r;
    remain_s   = remain_r;
    checksum_s = checksum_r;
    ftype_s    = ftype_r;
    len_s      = len_r;
    load_s     = load_r;
    exec_s     = exec_r;
    mem_addr_s = mem_addr_r;
    mem_rd_s   = 1'b0;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    tx_count_s = tx_count_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    error_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (is_supported(file_type)) begin
            state_s    = ST_HDR;
            hdr_idx_s  = 4'd0;
            ftype_s    = file_type;
            len_s      = prog_length;
            load_s     = load_point;
            exec_s     = exec_point;
            remain_s   = prog_length;
            checksum_s = 8'h00;
            mem_addr_s = (file_type == FT_BASIC) ? BASIC_BASE : load_point;
            tx_data_s  = QUOTE_BYTE;
            tx_valid_s = 1'b1;
            tx_count_s = 25'd0;
            busy_s     = 1'b1;
          end else begin
            error_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_HDR: begin
        if (xfer_s) begin
          tx_count_s = tx_count_r + 25'd1;
          if (hdr_idx_r == hdr_last_s) begin
            if (len_r == 16'd0) begin
              if (is_basic_s) begin
                state_s    = ST_FIN;
                tx_valid_s = 1'b0;
                done_s     = 1'b1;
                busy_s     = 1'b0;
              end else begin
                state_s   = ST_CHECK;
                tx_data_s = checksum_r;
              end
            end else begin
              state_s    = ST_RDREQ;
              tx_valid_s = 1'b0;
              mem_rd_s   = 1'b1;
            end
          end else begin
            hdr_idx_s = hdr_idx_r + 4'd1;
            tx_data_s = hdr_byte(hdr_idx_r + 4'd1, ftype_r, len_r, load_r, exec_r);
          end
        end else begin
          state_s = ST_HDR;
        end
      end

      ST_RDREQ: begin
        state_s = ST_RDWAIT;
      end

      ST_RDWAIT: begin
        state_s    = ST_BODY;
        tx_data_s  = mem_din;
        tx_valid_s = 1'b1;
        checksum_s = csum_add(checksum_r, mem_din);
      end

      ST_BODY: begin
        if (xfer_s) begin
          tx_count_s = tx_count_r + 25'd1;
          remain_s   = remain_r - 16'd1;
          mem_addr_s = mem_addr_r + 16'd1;
          if (remain_r == 16'd1) begin
            if (is_basic_s) begin
              state_s    = ST_FIN;
              tx_valid_s = 1'b0;
              done_s     = 1'b1;
              busy_s     = 1'b0;
            end else begin
              state_s   = ST_CHECK;
              tx_data_s = checksum_r;
            end
          end else begin
            state_s    = ST_RDREQ;
            tx_valid_s = 1'b0;
            mem_rd_s   = 1'b1;
          end
        end else begin
          state_s = ST_BODY;
        end
      end

      ST_CHECK: begin
        if (xfer_s) begin
          tx_count_s = tx_count_r + 25'd1;
          state_s    = ST_TRAILER;
          tx_data_s  = TRAILER_BYTE;
        end else begin
          state_s = ST_CHECK;
        end
      end

      ST_TRAILER: begin
        if (xfer_s) begin
          tx_count_s = tx_count_r + 25'd1;
          state_s    = ST_FIN;
          tx_valid_s = 1'b0;
          done_s     = 1'b1;
          busy_s     = 1'b0;
        end else begin
          state_s = ST_TRAILER;
        end
      end

      ST_FIN: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s    = ST_IDLE;
        tx_valid_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      hdr_idx_r  <= 4'd0;
      remain_r   <= 16'd0;
      checksum_r <= 8'h00;
      ftype_r    <= 8'h00;
      len_r      <= 16'd0;
      load_r     <= 16'd0;
      exec_r     <= 16'd0;
      mem_addr_r <= 16'd0;
      mem_rd_r   <= 1'b0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      tx_count_r <= 25'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      hdr_idx_r  <= hdr_idx_s;
      remain_r   <= remain_s;
      checksum_r <= checksum_s;
      ftype_r    <= ftype_s;
      len_r      <= len_s;
      load_r     <= load_s;
      exec_r     <= exec_s;
      mem_addr_r <= mem_addr_s;
      mem_rd_r   <= mem_rd_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      tx_count_r <= tx_count_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
    end
  end

endmodule

// File: tb/tb_cassette_save.sv
// Directed bench for cassette_save: memory model, byte/read capture monitors
// and a linear sequence of file transfers with hand-computed expectations.
module tb_cassette_save;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  file_type;
  logic [15:0] load_point, exec_point, prog_length;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [24:0] tx_count;
  logic        busy, done, error;

  logic        fixed_ready;
  logic        rand_ready;
  logic        rnd_bit;

  logic [7:0]  mem [0:65535];
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];
  logic [15:0] rd_q  [$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_at_done = 0;
  int stall_viol = 0;
  int stall_events = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  assign tx_ready = rand_ready ? rnd_bit : fixed_ready;

  cassette_save dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .file_type   (file_type),
    .load_point  (load_point),
    .exec_point  (exec_point),
    .prog_length (prog_length),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_din     (mem_din),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_count    (tx_count),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Random ready source, changed away from the active edge.
  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  // Memory model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_din <= mem[mem_addr];
      rd_q.push_back(mem_addr);
    end
  end

  // Capture transfers, done pulses and stall stability.
  always @(posedge clk) begin
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (done) begin
      done_cnt++;
      if (busy) busy_at_done++;
    end
    if (reset_n && prev_stall && !(tx_valid && tx_data == prev_data)) stall_viol++;
    if (tx_valid && !tx_ready) stall_events++;
    prev_stall = reset_n && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_b%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
    end
  endtask

  task automatic pulse_start(input logic [7:0] ft, input logic [15:0] lp, input logic [15:0] ep,
                             input logic [15:0] len);
    @(negedge clk);
    start = 1'b1; file_type = ft; load_point = lp; exec_point = ep; prog_length = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic clear_logs();
    got_q.delete();
    rd_q.delete();
  endtask

  initial begin
    int base_done;
    int n;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    reset_n = 1'b0; start = 1'b0; file_type = 8'h00;
    load_point = 16'h0; exec_point = 16'h0; prog_length = 16'h0;
    fixed_ready = 1'b1; rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_mem_rd",   32'(mem_rd),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_tx_data",  32'(tx_data),  32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_tx_count", 32'(tx_count), 32'h0);
    reset_n = 1'b1;

    // Machine-code file with header extension and check digit.
    mem[16'h8000] = 8'h01; mem[16'h8001] = 8'h02; mem[16'h8002] = 8'h03;
    clear_logs();
    pulse_start(8'h4D, 16'h8000, 16'h8010, 16'd3);
    check("m_first_valid", 32'(tx_valid), 32'd1);
    check("m_first_data",  32'(tx_data),  32'h22);
    check("m_busy",        32'(busy),     32'd1);
    wait_done("m", 200);
    exp_q = {8'h22, 8'h22, 8'h4D, 8'h03, 8'h00, 8'h00, 8'h80, 8'h10, 8'h80,
             8'h01, 8'h02, 8'h03, 8'h06, 8'h00};
    check_bytes("m");
    check("m_tx_count", 32'(tx_count), 32'd14);
    check("m_nreads", rd_q.size(), 32'd3);
    if (rd_q.size() == 3) check("m_rd2", 32'(rd_q[2]), 32'h8002);
    check("m_busy_at_done", busy_at_done, 32'd0);
    @(negedge clk);
    check("m_busy_after", 32'(busy), 32'd0);

    // BASIC file: body from the fixed base, no check digit or trailer.
    mem[16'h694D] = 8'hAA; mem[16'h694E] = 8'h55;
    clear_logs();
    pulse_start(8'h42, 16'h1234, 16'h0000, 16'd2);
    wait_done("b", 200);
    exp_q = {8'h22, 8'h22, 8'h42, 8'h02, 8'h00, 8'hAA, 8'h55};
    check_bytes("b");
    check("b_tx_count", 32'(tx_count), 32'd7);
    check("b_nreads", rd_q.size(), 32'd2);
    if (rd_q.size() == 2) begin
      check("b_rd0", 32'(rd_q[0]), 32'h694D);
      check("b_rd1", 32'(rd_q[1]), 32'h694E);
    end

    // Data file of zero length: no reads, check digit zero.
    clear_logs();
    pulse_start(8'h44, 16'h4000, 16'h0000, 16'd0);
    wait_done("d0", 200);
    exp_q = {8'h22, 8'h22, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    check_bytes("d0");
    check("d0_nreads", rd_q.size(), 32'd0);

    // Address wrap with a randomly stalling sink.
    mem[16'hFFFF] = 8'h9C; mem[16'h0000] = 8'h7A;
    clear_logs();
    stall_events = 0;
    rand_ready = 1'b1;
    pulse_start(8'h4D, 16'hFFFF, 16'h1234, 16'd2);
    wait_done("wrap", 600);
    rand_ready = 1'b0;
    exp_q = {8'h22, 8'h22, 8'h4D, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h34, 8'h12,
             8'h9C, 8'h7A, 8'h16, 8'h00};
    check_bytes("wrap");
    check("wrap_nreads", rd_q.size(), 32'd2);
    if (rd_q.size() == 2) begin
      check("wrap_rd0", 32'(rd_q[0]), 32'hFFFF);
      check("wrap_rd1", 32'(rd_q[1]), 32'h0000);
    end
    check("wrap_stalls_seen", 32'(stall_events > 0), 32'd1);
    check("wrap_stall_stable", stall_viol, 32'd0);

    // Unsupported type: error pulse, nothing sent.
    clear_logs();
    pulse_start(8'h58, 16'h0000, 16'h0000, 16'd4);
    check("err_pulse", 32'(error),    32'd1);
    check("err_valid", 32'(tx_valid), 32'd0);
    check("err_busy",  32'(busy),     32'd0);
    @(negedge clk);
    check("err_pulse_end", 32'(error), 32'd0);
    repeat (5) @(negedge clk);
    check("err_nbytes", got_q.size(), 32'd0);

    // Start while busy is ignored.
    mem[16'h0100] = 8'h10; mem[16'h0101] = 8'h20; mem[16'h0102] = 8'h30; mem[16'h0103] = 8'h40;
    clear_logs();
    base_done = done_cnt;
    pulse_start(8'h41, 16'h0100, 16'h0000, 16'd4);
    repeat (3) @(negedge clk);
    pulse_start(8'h4D, 16'h0000, 16'h0000, 16'd1);
    wait_done("a", 300);
    repeat (20) @(negedge clk);
    exp_q = {8'h22, 8'h22, 8'h41, 8'h04, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0, 8'h00};
    check_bytes("a");
    check("a_one_done", done_cnt - base_done, 32'd1);
    check("a_idle_busy", 32'(busy), 32'd0);

    // Reset during the body aborts without done; next file starts fresh.
    clear_logs();
    base_done = done_cnt;
    pulse_start(8'h44, 16'h0200, 16'h0000, 16'd5);
    n = 0;
    while (rd_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_body", 32'(rd_q.size() >= 2), 32'd1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy",  32'(busy),     32'd0);
    check("rst_mid_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_count", 32'(tx_count), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_no_done", done_cnt - base_done, 32'd0);
    check("rst_mid_idle_valid", 32'(tx_valid), 32'd0);
    mem[16'h0300] = 8'h5A;
    clear_logs();
    pulse_start(8'h44, 16'h0300, 16'h0000, 16'd1);
    wait_done("fresh", 200);
    exp_q = {8'h22, 8'h22, 8'h44, 8'h01, 8'h00, 8'h5A, 8'h5A, 8'h00};
    check_bytes("fresh");
    check("fresh_tx_count", 32'(tx_count), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cassette_save.md
CASSETTE_SAVE -- requirements
Module: cassette_save

Interface
REQ-001 The module SHALL have parameter TRAILER_BYTE, default 8'h00, giving the byte emitted after the check digit.
REQ-002 The module SHALL have parameter BASIC_BASE, default 16'h694D, giving the body source address for file type 'B'.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 start  in  1  one-cycle request to emit one file; honoured only in IDLE.
REQ-006 file_type  in  8  'h42 B, 'h4D M, 'h44 D, 'h41 A; sampled on start.
REQ-007 load_point, exec_point, prog_length  in  16 each  source address, exec address and body byte count; sampled on start.
REQ-008 mem_addr  out  16  memory read address.
REQ-009 mem_rd  out  1  one-cycle read strobe.
REQ-010 mem_din  in  8  read data, valid the cycle after mem_rd.
REQ-011 tx_data  out  8  outgoing TAP byte.
REQ-012 tx_valid  out  1  tx_data valid.
REQ-013 tx_ready  in  1  sink accepts; a transfer occurs on a cycle with tx_valid and tx_ready both high.
REQ-014 tx_count  out  25  number of bytes transferred in the current file.
REQ-015 busy  out  1  high from start acceptance until done.
REQ-016 done  out  1  one-cycle pulse after the last byte transfers.
REQ-017 error  out  1  one-cycle pulse when start carries an unsupported file_type.

Function
REQ-018 Byte order for every type: 'h22, 'h22, file_type, len_lo, len_hi.
REQ-019 For M only, the header continues with load_lo, load_hi, exec_lo, exec_hi.
REQ-020 After the header, the body SHALL follow: prog_length bytes read from consecutive addresses.
REQ-021 The body source SHALL be BASIC_BASE for B and load_point for M, D and A.
REQ-022 For M, D and A, the body SHALL be followed by the check digit (8-bit modulo-256 sum of the body bytes), then TRAILER_BYTE; B SHALL end after the body.
REQ-023 States: IDLE, HDR (index counter), RDREQ, RDWAIT, BODY, CHECK, TRAILER, FIN.
REQ-024 Transitions: IDLE-(start)->HDR; HDR-(last header byte accepted)->RDREQ, or CHECK/FIN when length is 0; RDREQ->RDWAIT->BODY; BODY-(accepted, bytes remaining)->RDREQ; BODY-(last byte accepted)->CHECK (B: FIN); CHECK->TRAILER->FIN; FIN->IDLE.
REQ-025 tx_valid SHALL rise the cycle after start is accepted, carrying 'h22.
REQ-026 While tx_valid is high and tx_ready is low, tx_data SHALL be held stable.
REQ-027 mem_rd SHALL pulse in RDREQ only; the body byte SHALL be registered from mem_din in RDWAIT and presented on tx_valid in BODY, 2 cycles after its mem_rd.
REQ-028 No new read SHALL be issued before the previous body byte transfers.
REQ-029 mem_addr SHALL increment modulo 2^16, wrapping 'hFFFF to 'h0000.
REQ-030 The length counter SHALL be 16 bits; prog_length 'hFFFF SHALL emit 65535 body bytes.
REQ-031 tx_count SHALL be cleared on start and incremented on each transfer.
REQ-032 done SHALL pulse in FIN and busy SHALL fall in the same cycle.
REQ-033 start while busy SHALL be ignored.
REQ-034 start with an unsupported type SHALL pulse error, emit no bytes and stay IDLE.
REQ-035 tx_ready high without tx_valid SHALL have no effect.

Reset
REQ-036 When reset_n is low at a clock edge: state=IDLE; tx_valid, mem_rd, busy, done, error=0; tx_data, mem_addr, tx_count, checksum=0.
REQ-037 Reset mid-file SHALL abort with no done pulse; the next start begins a fresh file.

Structure
REQ-038 Package cassette_pkg SHALL hold the state enum, file-type constants ('h42, 'h4D, 'h44, 'h41), the quote constant 'h22 and BASIC_BASE; this package is shared with the tape loader.
REQ-039 The block SHALL be a single module with no sub-modules; the checksum is an in-line 8-bit accumulator.

Verification
REQ-040 M, load 'h8000, exec 'h8010, len 3, mem 01 02 03, tx_ready=1 -> 22 22 4D 03 00 00 80 10 80 01 02 03 06 00; done; tx_count=14.
REQ-041 B, len 2, mem[694D]=AA, mem[694E]=55 -> 22 22 42 02 00 AA 55; no check digit; reads at 694D, 694E.
REQ-042 D, len 0 -> 22 22 44 00 00 00 00; no mem_rd.
REQ-043 M, load 'hFFFF, len 2, tx_ready toggling randomly -> addresses FFFF then 0000; tx_data stable while stalled; check digit = byte sum mod 256.
REQ-044 file_type 'h58 -> error pulse; no tx_valid; start mid-file ignored; reset_n low during body -> IDLE, no done.
